// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, defaults and a wrap helper for the UART transmit arbiter.
package uart_arb_pkg;
    localparam int N_REQ_DEF        = 4;
    localparam int BUSY_TIMEOUT_DEF = 15;
    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE} arb_state_e;
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin pick of the first request at or after rr_ptr.
module uart_rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         win,
    output logic                     valid
);
    localparam int PW = $clog2(N_REQ);
    logic [PW-1:0] idx;
    // Scan from the farthest slot back to rr_ptr so the nearest request wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) win = N_REQ'(1) << idx;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between N_REQ byte producers,
// with per-frame locking and a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_wr_en,
    input  logic               tx_busy,
    output logic               err_timeout
);
    localparam int            PW      = $clog2(N_REQ);
    localparam int            CW      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d, win_idx, cand_idx;
    logic             lock_q, lock_d, tx_wr_en_q, tx_wr_en_d, err_q, err_d, cand_ok, pick_any;
    logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d, pick_win;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .win    (pick_win),
        .valid  (pick_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) if (pick_win[i]) win_idx = PW'(i);
    end

    // While a frame is locked only its owner can be granted, whatever the pointer says.
    assign cand_ok  = lock_q ? req[owner_q] : pick_any;
    assign cand_idx = lock_q ? owner_q : win_idx;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        tx_wr_en_d = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (!tx_busy && cand_ok) begin
                state_d   = LOAD;
                owner_d   = cand_idx;
                grant_d   = N_REQ'(1) << cand_idx;
                ack_d     = N_REQ'(1) << cand_idx;
                tx_data_d = req_data[{cand_idx, 3'b000} +: 8];
                lock_d    = !req_last[cand_idx];
                rr_ptr_d  = req_last[cand_idx] ? PW'(wrap_inc(32'(cand_idx), N_REQ)) : rr_ptr_q;
            end
            LOAD: begin
                tx_wr_en_d = 1'b1;
                state_d    = STROBE;
            end
            STROBE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy) begin
                state_d = WAIT_DONE;
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (cnt_d == CNT_MAX) begin
                    err_d    = 1'b1;
                    lock_d   = 1'b0;
                    grant_d  = '0;
                    rr_ptr_d = PW'(wrap_inc(32'(owner_q), N_REQ));
                    state_d  = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) begin
                state_d = IDLE;
                grant_d = lock_q ? grant_q : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_q     <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_wr_en_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_wr_en_q <= tx_wr_en_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_wr_en    = tx_wr_en_q;
    assign err_timeout = err_q;
endmodule
